// File: rtl/shared_index_copy_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_index_copy_arbiter_pkg
// Description : Shared types and constants for the arbitrated bit-serial
//               copy engine (state encoding, requester identifiers).
// Revision    : 1.0 - initial release
// ============================================================================
package shared_index_copy_arbiter_pkg;

    // Copy engine sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requester identifiers, also used as bit positions in req/gnt vectors
    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

endpackage : shared_index_copy_arbiter_pkg
`default_nettype wire

// File: rtl/shared_index_copy_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : shared_index_copy_arbiter_if
// Description : Request / grant / destination bundle between the two
//               requesters (master side) and the copy arbiter (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface shared_index_copy_arbiter_if #(
    parameter int WIDTH = 4
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             req0;
    logic [WIDTH-1:0] src0;
    logic             req1;
    logic [WIDTH-1:0] src1;
    logic [1:0]       gnt;
    logic             busy;
    logic [IDX_W-1:0] idx;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] dst0;
    logic [WIDTH-1:0] dst1;

    modport master (
        output req0, src0, req1, src1,
        input  gnt, busy, idx, done0, done1, dst0, dst1
    );

    modport slave (
        input  req0, src0, req1, src1,
        output gnt, busy, idx, done0, done1, dst0, dst1
    );

endinterface : shared_index_copy_arbiter_if
`default_nettype wire

// File: rtl/shared_index_copy_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin picker. Purely combinational; returns a
//               one-hot pick. On contention the requester that did not win
//               last time is chosen. The caller owns the `last` register.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic [1:0] i_req,
    input  wire logic       i_last,
    output logic      [1:0] o_pick
);
    import shared_index_copy_arbiter_pkg::*;

    // Single requester wins outright; contention goes to the non-last one
    always_comb begin
        o_pick = 2'b00;
        if (i_req[REQ0] && i_req[REQ1]) begin
            o_pick = (i_last == 1'(REQ1)) ? 2'b01 : 2'b10;
        end else if (i_req[REQ0]) begin
            o_pick = 2'b01;
        end else if (i_req[REQ1]) begin
            o_pick = 2'b10;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/shared_index_copy_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_index_copy_arbiter
// Description : One shared bit-index counter and bit-serial copy engine,
//               time-shared between two requesters by round-robin. The
//               winner's source is snapshotted at grant and copied one bit
//               per clock into that requester's destination register.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_index_copy_arbiter #(
    parameter int WIDTH = 4
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    shared_index_copy_arbiter_if.slave     bus
);
    import shared_index_copy_arbiter_pkg::*;

    localparam int               IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WIDTH - 1);

    state_t           r_state,  w_state_nxt;
    logic [1:0]       r_gnt,    w_gnt_nxt;
    logic             r_busy,   w_busy_nxt;
    logic [IDX_W-1:0] r_idx,    w_idx_nxt;
    logic             r_done0,  w_done0_nxt;
    logic             r_done1,  w_done1_nxt;
    logic [WIDTH-1:0] r_dst0,   w_dst0_nxt;
    logic [WIDTH-1:0] r_dst1,   w_dst1_nxt;
    logic [WIDTH-1:0] r_shadow, w_shadow_nxt;
    logic             r_last,   w_last_nxt;
    logic [1:0]       w_pick;
    logic [WIDTH-1:0] w_wmask;

    rr_arb2 u_rr_arb2 (
        .i_req  ({bus.req1, bus.req0}),
        .i_last (r_last),
        .o_pick (w_pick)
    );

    // One-hot mask selecting the destination bit written this cycle
    assign w_wmask = {{(WIDTH-1){1'b0}}, 1'b1} << r_idx;

    // Next-state and next-output computation for the copy sequencer
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_busy_nxt   = r_busy;
        w_idx_nxt    = r_idx;
        w_done0_nxt  = 1'b0;
        w_done1_nxt  = 1'b0;
        w_dst0_nxt   = r_dst0;
        w_dst1_nxt   = r_dst1;
        w_shadow_nxt = r_shadow;
        w_last_nxt   = r_last;

        case (r_state)
            IDLE: begin
                if (|w_pick) begin
                    // Snapshot the winner's source so later src changes are ignored
                    w_shadow_nxt = w_pick[REQ1] ? bus.src1 : bus.src0;
                    w_gnt_nxt    = w_pick;
                    w_busy_nxt   = 1'b1;
                    w_idx_nxt    = '0;
                    w_state_nxt  = RUN;
                end
            end
            RUN: begin
                if (r_gnt[REQ1]) begin
                    w_dst1_nxt = (r_dst1 & ~w_wmask) | (r_shadow & w_wmask);
                end else begin
                    w_dst0_nxt = (r_dst0 & ~w_wmask) | (r_shadow & w_wmask);
                end
                if (r_idx == C_IDX_LAST) begin
                    // Completion pulse is visible during the DONE cycle
                    w_done0_nxt = r_gnt[REQ0];
                    w_done1_nxt = r_gnt[REQ1];
                    w_gnt_nxt   = 2'b00;
                    w_busy_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            DONE: begin
                // The done pulse identifies the requester just served
                w_last_nxt  = r_done1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any copy in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= 2'b00;
            r_busy   <= 1'b0;
            r_idx    <= '0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_dst0   <= '0;
            r_dst1   <= '0;
            r_shadow <= '0;
            r_last   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_busy   <= w_busy_nxt;
            r_idx    <= w_idx_nxt;
            r_done0  <= w_done0_nxt;
            r_done1  <= w_done1_nxt;
            r_dst0   <= w_dst0_nxt;
            r_dst1   <= w_dst1_nxt;
            r_shadow <= w_shadow_nxt;
            r_last   <= w_last_nxt;
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.busy  = r_busy;
    assign bus.idx   = r_idx;
    assign bus.done0 = r_done0;
    assign bus.done1 = r_done1;
    assign bus.dst0  = r_dst0;
    assign bus.dst1  = r_dst1;

endmodule : shared_index_copy_arbiter
`default_nettype wire

// File: tb/tb_shared_index_copy_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_index_copy_arbiter
// Description : Self-checking bench for shared_index_copy_arbiter. Expected
//               copy completions are queued when requests are driven and
//               checked when a done pulse appears. A WIDTH=1 instance is
//               exercised alongside the default WIDTH=4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_index_copy_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    shared_index_copy_arbiter_if #(.WIDTH(4)) bus  ();
    shared_index_copy_arbiter_if #(.WIDTH(1)) bus1 ();

    shared_index_copy_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    shared_index_copy_arbiter #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        int         id;
        logic [3:0] val;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] gnt_obs[$];
    logic [1:0] prev_gnt = 2'b00;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: record new grants and score every completion against the queue
    always @(negedge clk) begin
        exp_t e;
        if (bus.gnt != 2'b00 && prev_gnt == 2'b00) gnt_obs.push_back(bus.gnt);
        prev_gnt = bus.gnt;
        if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
            check("done_overlap", 32'({bus.done0, bus.done1} == 2'b11), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("done_id", bus.done1 ? 32'd1 : 32'd0, 32'(e.id));
                check("done_dst", 32'(e.id == 1 ? bus.dst1 : bus.dst0), 32'(e.val));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.src0 = '0; bus.src1 = '0;
        bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.src0 = '0; bus1.src1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        gnt_obs.delete();
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done0 === 1'b1 || bus.done1 === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic pulse_req0(input logic [3:0] v);
        @(negedge clk);
        bus.src0 = v; bus.req0 = 1'b1;
        sb_q.push_back('{id: 0, val: v});
        @(negedge clk);
        bus.req0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prog [4] = '{4'b0001, 4'b0001, 4'b0101, 4'b0101};
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        bit seen;

        // Reset state
        do_reset();
        check("rst_gnt",  32'(bus.gnt),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_idx",  32'(bus.idx),  32'd0);
        check("rst_done", 32'({bus.done0, bus.done1}), 32'd0);
        check("rst_dst0", 32'(bus.dst0), 32'd0);
        check("rst_dst1", 32'(bus.dst1), 32'd0);

        // Single copy of 0101 from requester 0, bit-by-bit progression
        pulse_req0(4'b0101);
        check("t1_gnt",  32'(bus.gnt),  32'd1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_idx0", 32'(bus.idx),  32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_dst0_prog", 32'(bus.dst0), 32'(prog[k]));
        end
        check("t1_done0", 32'(bus.done0), 32'd1);
        check("t1_busy_end", 32'(bus.busy), 32'd0);
        check("t1_dst1", 32'(bus.dst1), 32'd0);
        drain("t1_drain");

        // Simultaneous requests after reset: 0 first, one idle cycle, then 1
        do_reset();
        @(negedge clk);
        bus.src0 = 4'd5; bus.src1 = 4'd6; bus.req0 = 1'b1; bus.req1 = 1'b1;
        sb_q.push_back('{id: 0, val: 4'd5});
        sb_q.push_back('{id: 1, val: 4'd6});
        @(negedge clk);
        bus.req0 = 1'b0;
        wait_done(30, seen);
        check("t2_done0_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("t2_idle_gnt", 32'(bus.gnt), 32'd0);
        @(negedge clk);
        check("t2_gnt1", 32'(bus.gnt), 32'd2);
        wait_done(30, seen);
        check("t2_done1_seen", 32'(seen), 32'd1);
        bus.req1 = 1'b0;
        drain("t2_drain");
        check("t2_dst0", 32'(bus.dst0), 32'd5);
        check("t2_dst1", 32'(bus.dst1), 32'd6);

        // Both requests held: grants alternate across four copies
        do_reset();
        @(negedge clk);
        bus.src0 = 4'd5; bus.src1 = 4'd6; bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) sb_q.push_back('{id: k % 2, val: (k % 2) ? 4'd6 : 4'd5});
        for (int k = 0; k < 4; k++) begin
            wait_done(30, seen);
            check("t3_done_seen", 32'(seen), 32'd1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        drain("t3_drain");
        check("t3_ngrants", 32'(gnt_obs.size()), 32'd4);
        for (int i = 0; i < 4 && i < gnt_obs.size(); i++)
            check("t3_gnt_seq", 32'(gnt_obs[i]), 32'(exp_g[i]));

        // Source changed after grant: the snapshot is copied
        do_reset();
        pulse_req0(4'b0101);
        bus.src0 = 4'b1111;
        drain("t4_drain");
        check("t4_dst0", 32'(bus.dst0), 32'd5);

        // Reset mid-copy at idx 2 abandons it, then a fresh copy succeeds
        do_reset();
        @(negedge clk);
        bus.src0 = 4'd5; bus.req0 = 1'b1;
        @(negedge clk);
        bus.req0 = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_idx_pre", 32'(bus.idx), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_gnt",  32'(bus.gnt),  32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_idx",  32'(bus.idx),  32'd0);
        check("t5_dst0", 32'(bus.dst0), 32'd0);
        check("t5_done", 32'({bus.done0, bus.done1}), 32'd0);
        repeat (8) @(negedge clk);
        pulse_req0(4'b0101);
        drain("t5_drain");
        check("t5_dst0_after", 32'(bus.dst0), 32'd5);

        // WIDTH=1 instance: one RUN cycle, done two edges after request
        do_reset();
        @(negedge clk);
        bus1.src1 = 1'b1; bus1.req1 = 1'b1;
        @(negedge clk);
        bus1.req1 = 1'b0;
        check("w1_gnt",  32'(bus1.gnt),  32'd2);
        check("w1_busy", 32'(bus1.busy), 32'd1);
        check("w1_idx",  32'(bus1.idx),  32'd0);
        @(negedge clk);
        check("w1_done1", 32'(bus1.done1), 32'd1);
        check("w1_dst1",  32'(bus1.dst1),  32'd1);
        check("w1_dst0",  32'(bus1.dst0),  32'd0);
        check("w1_busy_end", 32'(bus1.busy), 32'd0);
        @(negedge clk);
        check("w1_done1_end", 32'(bus1.done1), 32'd0);
        check("w1_dst1_hold", 32'(bus1.dst1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shared_index_copy_arbiter
`default_nettype wire

// File: doc/shared_index_copy_arbiter.md
Name: shared_index_copy_arbiter

Overview:
- Owns a single bit-index counter and bit-serial copy engine shared by two requesters.
- Each requester asks to have its WIDTH-bit source copied, one bit per clock, into its own destination register.
- The block arbitrates round-robin, sequences the index from 0 to WIDTH-1 for the winner, and signals completion.
- It is the registered, arbitrated replacement for two processes that each walk a common loop variable.

Parameters:
- WIDTH, 4, bits per vector; legal range 1..32.
- IDX_W, derived localparam, index width = max(1, clog2(WIDTH)); not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req0  in  1  requester 0 asks for a copy
- src0  in  WIDTH  requester 0 source vector
- req1  in  1  requester 1 asks for a copy
- src1  in  WIDTH  requester 1 source vector
- gnt  out  2  one-hot grant; 2'b00 when no copy is in progress
- busy  out  1  high while in RUN
- idx  out  IDX_W  bit index being written this cycle (valid when busy)
- done0  out  1  one-cycle pulse: requester 0 copy complete
- done1  out  1  one-cycle pulse: requester 1 copy complete
- dst0  out  WIDTH  requester 0 destination register
- dst1  out  WIDTH  requester 1 destination register

Behaviour:
- Reset, applied when rst_n is low at a clk edge:
  - state=IDLE, gnt=0, busy=0, idx=0, done0=done1=0, dst0=dst1=0, last=1 (requester 0 wins first).
- Reset has priority over everything. Reset mid-RUN abandons the copy, clears the partial dst, and produces no done pulse.
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req is sampled high, grant one requester.
  - If only one requests, grant it.
  - If both request, grant the requester that is not `last`.
  - On the grant edge: latch that requester's src into an internal shadow, set gnt one-hot, busy=1, idx=0, go to RUN.
  - dst of the winner is not cleared at grant.
- RUN, each cycle:
  - dst_w[idx] <= shadow[idx]; the other bits of dst_w and the other dst are unchanged.
  - If idx==WIDTH-1, go to DONE with busy=0 and idx=0; otherwise idx <= idx+1.
- DONE, one cycle:
  - done_w=1, gnt=0, last<=winner; go to IDLE.
  - No grant is issued in DONE, so at least one IDLE cycle separates copies.
- Latency: req sampled at edge E gives RUN on edges E+1..E+WIDTH and done high during the cycle after edge E+WIDTH. Total: WIDTH+1 edges to done.
- src changes after the grant edge are ignored; the shadow is used.
- req deasserting during RUN is ignored; the copy completes and done still pulses.
- A req still high in IDLE after done is treated as a new request. Requesters should drop req in the done cycle.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1...
- WIDTH=1: RUN lasts one cycle, idx stays 0, and IDX_W=1.
- dst holds its value indefinitely between copies.

Decomposition:
- Shared package: state enum (IDLE, RUN, DONE) and requester-ID constants (REQ0=0, REQ1=1).
- One natural sub-module, rr_arb2: a two-way round-robin picker that takes req[1:0] and last and returns a one-hot pick. It is combinational; the parent registers `last`.
- The index counter and the dst write-enables stay in the parent.

Test Plan:
- WIDTH=4, reset, then src0=4'b0101 with req0 for 1 cycle:
  - gnt=01 next edge; dst0 progresses 0001, 0001, 0101, 0101 over RUN edges.
  - done0 pulses 5 edges after req; dst1 stays 0000.
- req0 (src0=5) and req1 (src1=6) asserted on the same edge after reset:
  - requester 0 served first; dst0=0101, done0.
  - One IDLE cycle, then requester 1 served; dst1=0110, done1.
- Both reqs held high for 4 copies: gnt sequence 01,10,01,10; done pulses alternate and never overlap.
- src0 changed from 5 to 4'b1111 one cycle after grant: dst0 ends 0101.
- rst_n low for one edge when idx==2 on a copy of 5: next cycle all outputs are reset values (dst0=0000, no done0); a subsequent req0 copies correctly to 0101.
- WIDTH=1 build, src1=1, req1 pulse: one RUN cycle, dst1=1, done1 pulses 2 edges after req.
